// File: rtl/led_pwm_pkg.sv
// Shared constants, types and helpers for the LED PWM brightness stage.
//   LED_COUNT  number of LEDs / duty registers
//   DUTY_W     duty and step counter width
//   PWM_STEPS  steps per PWM period (0..PWM_STEPS-1)
package led_pwm_pkg;

  localparam int LED_COUNT = 8;
  localparam int DUTY_W    = 8;
  localparam int PWM_STEPS = 255;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 16;

  typedef logic [DUTY_W-1:0] duty_t;

  // Last step index of a period; the counter wraps from here back to 0.
  localparam duty_t STEP_LAST = DUTY_W'(PWM_STEPS - 1);

  // One decoded register write request.
  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    duty_t             duty;
  } wr_req_t;

  // A pin is lit while the step counter is below its duty. Since steps
  // only reach PWM_STEPS-1, duty 255 is always on and duty 0 always off.
  function automatic logic pwm_on(input duty_t step, input duty_t duty);
    return step < duty;
  endfunction

endpackage

// File: rtl/led_pwm_if.sv
// Peripheral bus for the duty register file.
//   en       select for this block
//   wr_en    write strobe, qualified by en
//   addr     duty register index (LED number)
//   data     write data, duty in the low byte
//   rd_data  combinational read-back of the pending duty at addr
interface led_pwm_if;
  import led_pwm_pkg::*;

  logic              en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] rd_data;

  modport master (output en, wr_en, addr, data, input rd_data);
  modport slave  (input en, wr_en, addr, data, output rd_data);

endinterface

// File: rtl/led_pwm_timebase.sv
// PWM timebase: prescaler plus step counter.
//   clk, rst_n   clock, async active-low reset
//   step_next    step value after the current edge (what the pins use)
//   period_end   registered, high during the last clk of each PWM period
module pwm_timebase
  import led_pwm_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  output duty_t step_next,
  output logic  period_end
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc, presc_next;
  duty_t         step;
  logic          tick;

  always_comb begin
    tick       = (presc == PMAX);
    presc_next = tick ? '0 : presc + 1'b1;
    step_next  = step;
    if (tick) step_next = (step == STEP_LAST) ? '0 : step + 1'b1;
  end

  // period_end is computed from the next state so the flop is high exactly
  // while the counters sit on the final prescale slot of step 254.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      step       <= '0;
      period_end <= 1'b0;
    end else begin
      presc      <= presc_next;
      step       <= step_next;
      period_end <= (presc_next == PMAX) && (step_next == STEP_LAST);
    end
  end

endmodule

// File: rtl/led_pwm.sv
// LED brightness stage: per-LED PWM dimming of the on/off LED byte.
//   clk, rst_n   clock, async active-low reset
//   bus          duty register bus (slave side)
//   led_in       on/off byte from the LED output register
//   period_end   one-cycle pulse on the last clk of each PWM period
//   led_pin      PWM-modulated pin drive
// Writes land in a pending register file; the active file that drives the
// comparators is refreshed only at period boundaries so a period is never
// cut short or stretched by a duty change.
module led_pwm
  import led_pwm_pkg::*;
#(
  parameter int          PRESCALE = 16,
  parameter logic [7:0]  DUTY_RST = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_pwm_if.slave             bus,
  input  logic [LED_COUNT-1:0] led_in,
  output logic                 period_end,
  output logic [LED_COUNT-1:0] led_pin
);

  logic [LED_COUNT-1:0][DUTY_W-1:0] pend, pend_nxt;
  logic [LED_COUNT-1:0][DUTY_W-1:0] act, act_nxt;
  duty_t   step_next;
  wr_req_t wr;
  logic    unused_hi;

  pwm_timebase #(.PRESCALE(PRESCALE)) u_tb (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_next  (step_next),
    .period_end (period_end)
  );

  assign wr = '{vld: bus.en && bus.wr_en, addr: bus.addr, duty: bus.data[DUTY_W-1:0]};
  assign unused_hi = ^bus.data[DATA_W-1:DUTY_W];

  // Read-back shows the pending value, pre-write within the cycle.
  assign bus.rd_data = {{(DATA_W-DUTY_W){1'b0}}, pend[bus.addr]};

  // The boundary copy takes pend_nxt so a write on the period_end cycle is
  // part of the very next period.
  always_comb begin
    pend_nxt = pend;
    if (wr.vld) pend_nxt[wr.addr] = wr.duty;
    act_nxt = period_end ? pend_nxt : act;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= {LED_COUNT{DUTY_RST}};
      act  <= {LED_COUNT{DUTY_RST}};
    end else begin
      pend <= pend_nxt;
      act  <= act_nxt;
    end
  end

  // Pins follow post-edge step/duty, so the first clk of a new period
  // already reflects the new duty, and led_in lands after one clk.
  for (genvar g = 0; g < LED_COUNT; g++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) led_pin[g] <= 1'b0;
      else        led_pin[g] <= led_in[g] && pwm_on(step_next, act_nxt[g]);
    end
  end

endmodule

// File: tb/tb_led_pwm.sv
module tb_led_pwm;
  import led_pwm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] led_in = 8'h00;
  logic       pe_a, pe_b;
  logic [7:0] pin_a, pin_b;

  led_pwm_if bus_a();
  led_pwm_if bus_b();

  led_pwm #(.PRESCALE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .led_in(led_in),
    .period_end(pe_a), .led_pin(pin_a));

  led_pwm #(.PRESCALE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .led_in(led_in),
    .period_end(pe_b), .led_pin(pin_b));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: time is the number of clock edges since reset; every
  // quantity follows from that count and the register contents.
  int         presc[2] = '{1, 3};
  logic [7:0] m_pend[2][8];
  logic [7:0] m_act[2][8];
  int         m_n[2];
  logic [7:0] m_pin[2];
  logic       m_pe[2];

  function automatic logic [7:0] pin_of(input int d);
    return (d == 0) ? pin_a : pin_b;
  endfunction

  function automatic logic pe_of(input int d);
    return (d == 0) ? pe_a : pe_b;
  endfunction

  function automatic logic [15:0] rd_of(input int d);
    return (d == 0) ? bus_a.rd_data : bus_b.rd_data;
  endfunction

  task automatic set_bus(input logic e, input logic w, input logic [2:0] a, input logic [15:0] dat);
    bus_a.en = e; bus_a.wr_en = w; bus_a.addr = a; bus_a.data = dat;
    bus_b.en = e; bus_b.wr_en = w; bus_b.addr = a; bus_b.data = dat;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_n[d] = 0;
      m_pin[d] = 8'h00;
      m_pe[d] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_pend[d][i] = 8'hFF;
        m_act[d][i]  = 8'hFF;
      end
    end
  endtask

  // Advance one clock: update the model from the current inputs, then
  // let the DUT take the edge and settle.
  task automatic cyc();
    for (int d = 0; d < 2; d++) begin
      int len;
      int st;
      len = 255 * presc[d];
      if (bus_a.en && bus_a.wr_en) m_pend[d][bus_a.addr] = bus_a.data[7:0];
      if (m_n[d] % len == len - 1)
        for (int i = 0; i < 8; i++) m_act[d][i] = m_pend[d][i];
      m_n[d]++;
      st = (m_n[d] / presc[d]) % 255;
      for (int i = 0; i < 8; i++) m_pin[d][i] = led_in[i] && (st < int'(m_act[d][i]));
      m_pe[d] = (m_n[d] % len == len - 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    set_bus(1'b0, 1'b0, 3'd0, 16'h0000);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // Dirty the state first so reset has something to undo.
    apply_reset();
    led_in = 8'hFF;
    set_bus(1'b1, 1'b1, 3'd4, 16'h0033);
    cyc();
    set_bus(1'b0, 1'b0, 3'd0, 16'h0000);
    repeat (40) cyc();
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (pin_of(d) !== 8'h00) begin
        fails++; $display("FAIL reset_pin dut%0d got %h want 00", d, pin_of(d));
      end
      tests++;
      if (pe_of(d) !== 1'b0) begin
        fails++; $display("FAIL reset_pe dut%0d got %b want 0", d, pe_of(d));
      end
    end
    for (int a = 0; a < 8; a++) begin
      set_bus(1'b0, 1'b0, 3'(a), 16'h0000);
      #0.5;
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (rd_of(d) !== 16'h00FF) begin
          fails++; $display("FAIL reset_rd dut%0d addr %0d got %h want 00ff", d, a, rd_of(d));
        end
      end
    end
    led_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    // Step restarts at 0: first period_end of dut_a comes after 254 edges.
    begin
      int k;
      k = 0;
      while (pe_a !== 1'b1 && k < 400) begin cyc(); k++; end
      tests++;
      if (k != 254) begin
        fails++; $display("FAIL reset_first_period cycles got %0d want 254", k);
      end
    end
  endtask

  task automatic test_full_on();
    apply_reset();
    led_in = 8'hA5;
    cyc();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (pin_of(d) !== 8'hA5) begin
        fails++; $display("FAIL full_on_first dut%0d got %h want a5", d, pin_of(d));
      end
    end
    for (int k = 0; k < 800; k++) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (pin_of(d) !== 8'hA5) begin
          fails++; $display("FAIL full_on_hold dut%0d cyc %0d got %h want a5", d, k, pin_of(d));
        end
      end
    end
  endtask

  task automatic test_duty64();
    int k, cnt;
    apply_reset();
    led_in = 8'h04;
    set_bus(1'b1, 1'b1, 3'd2, 16'h0040);
    cyc();
    set_bus(1'b0, 1'b0, 3'd0, 16'h0000);
    k = 0;
    while (pe_a !== 1'b1 && k < 400) begin cyc(); k++; end
    tests++;
    if (pe_a !== 1'b1) begin
      fails++; $display("FAIL duty64_boundary timeout got %b want 1", pe_a);
    end
    cnt = 0;
    for (int j = 0; j < 255; j++) begin
      cyc();
      cnt += int'(pin_a[2]);
      tests++;
      if (pin_a !== m_pin[0]) begin
        fails++; $display("FAIL duty64_pin step %0d got %h want %h", j, pin_a, m_pin[0]);
      end
      if (j == 63 || j == 64) begin
        tests++;
        if (pin_a[2] !== (j == 63)) begin
          fails++; $display("FAIL duty64_edge step %0d got %b want %b", j, pin_a[2], j == 63);
        end
      end
    end
    tests++;
    if (cnt != 64) begin
      fails++; $display("FAIL duty64_count got %0d want 64", cnt);
    end
  endtask

  task automatic test_mid_write();
    int k, cnt;
    apply_reset();
    led_in = 8'hFF;
    repeat (100) cyc();
    set_bus(1'b1, 1'b1, 3'd0, 16'h0000);
    cyc();
    set_bus(1'b0, 1'b0, 3'd0, 16'h0000);
    k = 0;
    while (pe_a !== 1'b1 && k < 400) begin
      tests++;
      if (pin_a[0] !== 1'b1) begin
        fails++; $display("FAIL mid_write_hold cyc %0d got %b want 1", k, pin_a[0]);
      end
      cyc(); k++;
    end
    tests++;
    if (pe_a !== 1'b1) begin
      fails++; $display("FAIL mid_write_boundary timeout got %b want 1", pe_a);
    end
    cnt = 0;
    for (int j = 0; j < 255; j++) begin
      cyc();
      cnt += int'(pin_a[0]);
    end
    tests++;
    if (cnt != 0) begin
      fails++; $display("FAIL mid_write_off high_count got %0d want 0", cnt);
    end
    tests++;
    if (pin_a[7:1] !== 7'h7F) begin
      fails++; $display("FAIL mid_write_others got %h want 7f", pin_a[7:1]);
    end
  endtask

  task automatic test_write_on_pe();
    int k, cnt;
    apply_reset();
    led_in = 8'hFF;
    k = 0;
    while (pe_a !== 1'b1 && k < 400) begin cyc(); k++; end
    tests++;
    if (pe_a !== 1'b1) begin
      fails++; $display("FAIL pe_write_boundary timeout got %b want 1", pe_a);
    end
    set_bus(1'b1, 1'b1, 3'd5, 16'h0080);
    #1;
    tests++;
    if (bus_a.rd_data !== 16'h00FF) begin
      fails++; $display("FAIL pe_write_old_read got %h want 00ff", bus_a.rd_data);
    end
    cyc();
    set_bus(1'b0, 1'b0, 3'd5, 16'h0000);
    cnt = int'(pin_a[5]);
    for (int j = 1; j < 255; j++) begin
      cyc();
      cnt += int'(pin_a[5]);
    end
    tests++;
    if (cnt != 128) begin
      fails++; $display("FAIL pe_write_count got %0d want 128", cnt);
    end
    #1;
    tests++;
    if (bus_a.rd_data !== 16'h0080) begin
      fails++; $display("FAIL pe_write_read got %h want 0080", bus_a.rd_data);
    end
  endtask

  task automatic test_en_gate();
    apply_reset();
    set_bus(1'b0, 1'b1, 3'd3, 16'h0010);
    cyc();
    set_bus(1'b1, 1'b0, 3'd3, 16'h0010);
    cyc();
    set_bus(1'b0, 1'b0, 3'd3, 16'h0000);
    #1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (rd_of(d) !== 16'h00FF) begin
        fails++; $display("FAIL en_gate dut%0d got %h want 00ff", d, rd_of(d));
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 4000; k++) begin
      logic [15:0] dat;
      if ($urandom_range(0, 15) == 0) led_in = 8'($urandom);
      dat = 16'($urandom);
      case ($urandom_range(0, 3))
        0: dat[7:0] = 8'h00;
        1: dat[7:0] = 8'hFF;
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0)
        set_bus(1'b1, 1'b1, 3'($urandom), dat);
      else
        set_bus(1'($urandom), 1'b0, 3'($urandom), dat);
      #1;
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (rd_of(d) !== {8'h00, m_pend[d][bus_a.addr]}) begin
          fails++; $display("FAIL rand_rd dut%0d cyc %0d got %h want %h", d, k, rd_of(d), {8'h00, m_pend[d][bus_a.addr]});
        end
      end
      cyc();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (pin_of(d) !== m_pin[d]) begin
          fails++; $display("FAIL rand_pin dut%0d cyc %0d got %h want %h", d, k, pin_of(d), m_pin[d]);
        end
        tests++;
        if (pe_of(d) !== m_pe[d]) begin
          fails++; $display("FAIL rand_pe dut%0d cyc %0d got %b want %b", d, k, pe_of(d), m_pe[d]);
        end
      end
    end
  endtask

  initial begin
    set_bus(1'b0, 1'b0, 3'd0, 16'h0000);
    model_reset();
    #12;
    test_reset();
    test_full_on();
    test_duty64();
    test_mid_write();
    test_write_on_pe();
    test_en_gate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
